// File: rtl/ppu_timing_gen.sv
// NTSC PPU raster timing: dot/scanline counters, vblank flag, NMI and frame markers (clk_mst domain).
// Define PPU_ODD_FRAME_SKIP_EN to drop one dot from odd frames while rendering is enabled.
module ppu_timing_gen #(
  parameter int unsigned DOTS_PER_LINE   = 341,
  parameter int unsigned LINES_PER_FRAME = 262,
  parameter int unsigned VISIBLE_DOTS    = 256,
  parameter int unsigned VISIBLE_LINES   = 240,
  parameter int unsigned VBLANK_LINE     = 241
) (
  input  logic       clk_mst,
  input  logic       rst_mst,
  input  logic       clk_en_ppu,
  input  logic       rendering_en,
  input  logic       nmi_en,
  input  logic       status_rd,
  output logic [8:0] dot,
  output logic [8:0] scanline,
  output logic       visible,
  output logic       vblank,
  output logic       nmi_n,
  output logic       frame_start,
  output logic       frame_odd
);

  localparam logic [8:0] DotMax    = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] LineMax   = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VisDots   = 9'(VISIBLE_DOTS);
  localparam logic [8:0] VisLines  = 9'(VISIBLE_LINES);
  localparam logic [8:0] VblLine   = 9'(VBLANK_LINE);

  logic [8:0] dot_d;
  logic [8:0] line_d;
  logic       enter_frame;
  logic       vbl_set;
  logic       vbl_clr;
  logic       vblank_d;
  logic       visible_d;

  always_comb begin
    dot_d  = dot;
    line_d = scanline;
    if (clk_en_ppu) begin
      if (dot == DotMax) begin
        dot_d  = 9'd0;
        line_d = (scanline == LineMax) ? 9'd0 : scanline + 9'd1;
      end else begin
        dot_d = dot + 9'd1;
      end
`ifdef PPU_ODD_FRAME_SKIP_EN
      // Odd rendered frames jump straight from the second-to-last pre-render dot to (0,0).
      if (scanline == LineMax && dot == DotMax - 9'd1 && frame_odd && rendering_en) begin
        dot_d  = 9'd0;
        line_d = 9'd0;
      end
`endif
    end
  end

`ifndef PPU_ODD_FRAME_SKIP_EN
  logic unused_rendering_en;
  assign unused_rendering_en = rendering_en;
`endif

  assign enter_frame = clk_en_ppu && (dot_d == 9'd0) && (line_d == 9'd0);
  assign vbl_set     = clk_en_ppu && (line_d == VblLine) && (dot_d == 9'd1);
  assign vbl_clr     = clk_en_ppu && (line_d == LineMax) && (dot_d == 9'd1);
  assign visible_d   = (line_d < VisLines) && (dot_d >= 9'd1) && (dot_d <= VisDots);

  // A status read wins over both set and clear, which also covers the set/read race.
  always_comb begin
    vblank_d = vblank;
    if (status_rd) begin
      vblank_d = 1'b0;
    end else if (vbl_set) begin
      vblank_d = 1'b1;
    end else if (vbl_clr) begin
      vblank_d = 1'b0;
    end
  end

  always_ff @(posedge clk_mst or posedge rst_mst) begin
    if (rst_mst) begin
      dot         <= 9'd0;
      scanline    <= LineMax;
      visible     <= 1'b0;
      vblank      <= 1'b0;
      nmi_n       <= 1'b1;
      frame_start <= 1'b0;
      frame_odd   <= 1'b0;
    end else begin
      dot         <= dot_d;
      scanline    <= line_d;
      visible     <= visible_d;
      vblank      <= vblank_d;
      nmi_n       <= ~(vblank & nmi_en);
      frame_start <= enter_frame;
      if (enter_frame) begin
        frame_odd <= ~frame_odd;
      end
    end
  end

endmodule
